// File: rtl/assoc_wb_cache_if.sv
// Bus bundle for assoc_wb_cache: CPU request/response signals plus the
// line-granular memory request/response port.
interface assoc_wb_cache_if #(
    parameter int LINE_SIZE = 16
) ();
    localparam int OFF_W = $clog2(LINE_SIZE);

    logic                    is_input_valid;
    logic [31:0]             addr;
    logic                    mem_read;
    logic                    mem_write;
    logic [31:0]             din;
    logic                    is_ready;
    logic                    is_output_valid;
    logic [31:0]             dout;
    logic                    is_hit;

    logic                    mreq_valid;
    logic                    mreq_ready;
    logic                    mreq_write;
    logic [31-OFF_W:0]       mreq_addr;
    logic [8*LINE_SIZE-1:0]  mreq_data;
    logic                    mresp_valid;
    logic [8*LINE_SIZE-1:0]  mresp_data;

    // slave is the cache's view; master is the CPU/memory environment's view
    modport slave (
        input  is_input_valid, addr, mem_read, mem_write, din,
        input  mreq_ready, mresp_valid, mresp_data,
        output is_ready, is_output_valid, dout, is_hit,
        output mreq_valid, mreq_write, mreq_addr, mreq_data
    );

    modport master (
        output is_input_valid, addr, mem_read, mem_write, din,
        output mreq_ready, mresp_valid, mresp_data,
        input  is_ready, is_output_valid, dout, is_hit,
        input  mreq_valid, mreq_write, mreq_addr, mreq_data
    );
endinterface

// File: rtl/assoc_wb_cache.sv
// N-way set-associative write-back/write-allocate cache with true-LRU.
// Optional statistics counters are enabled with `define CACHE_STATS_EN.
module assoc_wb_cache #(
    parameter int LINE_SIZE = 16,
    parameter int NUM_SETS  = 16,
    parameter int NUM_WAYS  = 2
) (
    input  logic        clk,
    input  logic        reset,
    assoc_wb_cache_if.slave bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] stat_access,
    output logic [31:0] stat_hit,
    output logic [31:0] stat_writeback
`endif
);
    localparam int OFF_W  = $clog2(LINE_SIZE);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int AGE_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int LINE_W = 8 * LINE_SIZE;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITE_BACK, FILL_REQ, FILL_WAIT} state_t;

    state_t state, next_state;

    logic [NUM_SETS-1:0] valid_mem [NUM_WAYS];
    logic [NUM_SETS-1:0] dirty_mem [NUM_WAYS];
    logic [TAG_W-1:0]    tag_mem   [NUM_WAYS][NUM_SETS];
    logic [LINE_W-1:0]   data_mem  [NUM_WAYS][NUM_SETS];
    logic [AGE_W-1:0]    age_mem   [NUM_WAYS][NUM_SETS];

    logic [31:0]       req_addr;
    logic              req_read, req_write, miss_flag;
    logic [31:0]       req_din;
    logic [AGE_W-1:0]  victim_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-3:0]  req_word;
    logic              hit, is_access;
    logic [AGE_W-1:0]  hit_way, victim;
    logic [LINE_W-1:0] hit_line;
    logic              unused_addr_bits;

    assign req_tag          = req_addr[31:IDX_W+OFF_W];
    assign req_idx          = req_addr[IDX_W+OFF_W-1:OFF_W];
    assign req_word         = req_addr[OFF_W-1:2];
    assign is_access        = req_read | req_write;
    assign hit_line         = data_mem[hit_way][req_idx];
    assign unused_addr_bits = ^req_addr[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_mem[w][req_idx] && tag_mem[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    // Lowest invalid way wins; otherwise the oldest way is replaced
    always_comb begin
        victim = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (age_mem[w][req_idx] == AGE_W'(NUM_WAYS - 1)) victim = AGE_W'(w);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_mem[w][req_idx]) victim = AGE_W'(w);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (bus.is_input_valid) next_state = COMPARE;
            COMPARE: begin
                if (!is_access || hit)
                    next_state = IDLE;
                else if (valid_mem[victim][req_idx] && dirty_mem[victim][req_idx])
                    next_state = WRITE_BACK;
                else
                    next_state = FILL_REQ;
            end
            WRITE_BACK: if (bus.mreq_ready)  next_state = FILL_REQ;
            FILL_REQ:   if (bus.mreq_ready)  next_state = FILL_WAIT;
            FILL_WAIT:  if (bus.mresp_valid) next_state = COMPARE;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.is_ready        = 1'b0;
        bus.is_output_valid = 1'b0;
        bus.dout            = '0;
        bus.is_hit          = 1'b0;
        bus.mreq_valid      = 1'b0;
        bus.mreq_write      = 1'b0;
        bus.mreq_addr       = '0;
        bus.mreq_data       = '0;
        case (state)
            IDLE: bus.is_ready = 1'b1;
            COMPARE: begin
                if (!is_access || hit) begin
                    bus.is_output_valid = 1'b1;
                    bus.dout            = hit ? hit_line[{req_word, 5'd0} +: 32] : 32'd0;
                    bus.is_hit          = hit & ~miss_flag;
                end
            end
            WRITE_BACK: begin
                bus.mreq_valid = 1'b1;
                bus.mreq_write = 1'b1;
                bus.mreq_addr  = {tag_mem[victim_q][req_idx], req_idx};
                bus.mreq_data  = data_mem[victim_q][req_idx];
            end
            FILL_REQ: begin
                bus.mreq_valid = 1'b1;
                bus.mreq_addr  = req_addr[31:OFF_W];
            end
            default: ;
        endcase
    end

    // Request latch; the victim is frozen at the miss so later LRU/valid changes cannot move it
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr  <= '0;
            req_read  <= 1'b0;
            req_write <= 1'b0;
            req_din   <= '0;
            miss_flag <= 1'b0;
            victim_q  <= '0;
        end else if (state == IDLE && bus.is_input_valid) begin
            req_addr  <= bus.addr;
            req_read  <= bus.mem_read;
            req_write <= bus.mem_write;
            req_din   <= bus.din;
            miss_flag <= 1'b0;
        end else if (state == COMPARE && is_access && !hit) begin
            miss_flag <= 1'b1;
            victim_q  <= victim;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                valid_mem[w] <= '0;
                dirty_mem[w] <= '0;
                for (int s = 0; s < NUM_SETS; s++) age_mem[w][s] <= AGE_W'(w);
            end
        end else begin
            if (state == COMPARE && is_access && hit) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (AGE_W'(w) == hit_way)
                        age_mem[w][req_idx] <= '0;
                    else if (age_mem[w][req_idx] < age_mem[hit_way][req_idx])
                        age_mem[w][req_idx] <= age_mem[w][req_idx] + AGE_W'(1);
                end
                if (req_write) dirty_mem[hit_way][req_idx] <= 1'b1;
            end
            if (state == WRITE_BACK && bus.mreq_ready)
                dirty_mem[victim_q][req_idx] <= 1'b0;
            if (state == FILL_WAIT && bus.mresp_valid) begin
                valid_mem[victim_q][req_idx] <= 1'b1;
                dirty_mem[victim_q][req_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == COMPARE && req_write && hit)
            data_mem[hit_way][req_idx][{req_word, 5'd0} +: 32] <= req_din;
        if (state == FILL_WAIT && bus.mresp_valid) begin
            data_mem[victim_q][req_idx] <= bus.mresp_data;
            tag_mem[victim_q][req_idx]  <= req_tag;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_access    <= '0;
            stat_hit       <= '0;
            stat_writeback <= '0;
        end else begin
            if (bus.is_output_valid) begin
                stat_access <= stat_access + 32'd1;
                if (bus.is_hit) stat_hit <= stat_hit + 32'd1;
            end
            if (state == WRITE_BACK && bus.mreq_ready)
                stat_writeback <= stat_writeback + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_assoc_wb_cache.sv
// Directed self-checking bench for assoc_wb_cache (2 ways, 16 sets, 16-byte lines)
// with a behavioural backing memory that stores written-back lines.
module tb_assoc_wb_cache;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    assoc_wb_cache_if #(.LINE_SIZE(16)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] stat_access, stat_hit, stat_writeback;
`endif

    assoc_wb_cache #(.LINE_SIZE(16), .NUM_SETS(16), .NUM_WAYS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CACHE_STATS_EN
        ,
        .stat_access    (stat_access),
        .stat_hit       (stat_hit),
        .stat_writeback (stat_writeback)
`endif
    );

    int checks_total  = 0;
    int checks_passed = 0;

    int ready_delay  = 0;
    int fill_latency = 5;
    int wait_cnt = 0, resp_cnt = 0;
    bit resp_pending = 0;
    logic [127:0] resp_line;
    int wb_count = 0, fill_count = 0, seq = 0, wb_seq = 0, fill_seq = 0;
    int mreq_cycles = 0, overlap_cycles = 0;
    logic [27:0]  last_wb_addr, last_fill_addr, hold_addr;
    logic [127:0] last_wb_data, hold_data;
    logic         hold_write;
    logic [127:0] mem_store [int];

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    function automatic logic [127:0] model_line(input int line_addr);
        logic [127:0] l;
        if (mem_store.exists(line_addr)) return mem_store[line_addr];
        for (int w = 0; w < 4; w++) l[32*w +: 32] = 32'hA000_0000 + 32'(line_addr * 256 + w);
        return l;
    endfunction

    // Memory responder: optional ready stall, fixed fill latency, logs every handshake
    initial begin
        bus.mreq_ready  = 1'b0;
        bus.mresp_valid = 1'b0;
        bus.mresp_data  = '0;
        forever begin
            @(negedge clk);
            bus.mreq_ready  = 1'b0;
            bus.mresp_valid = 1'b0;
            if (bus.mreq_valid) mreq_cycles++;
            if (bus.mreq_valid && bus.is_output_valid) overlap_cycles++;
            if (reset) begin
                resp_pending = 0;
                wait_cnt     = 0;
            end else if (resp_pending) begin
                if (resp_cnt <= 1) begin
                    bus.mresp_valid = 1'b1;
                    bus.mresp_data  = resp_line;
                    resp_pending    = 0;
                end else resp_cnt--;
            end else if (bus.mreq_valid) begin
                if (wait_cnt == 0) begin
                    hold_addr  = bus.mreq_addr;
                    hold_data  = bus.mreq_data;
                    hold_write = bus.mreq_write;
                end else begin
                    checkOutput("hold_addr",  bus.mreq_addr,  hold_addr);
                    checkOutput("hold_data",  bus.mreq_data,  hold_data);
                    checkOutput("hold_write", bus.mreq_write, hold_write);
                end
                if (wait_cnt < ready_delay) wait_cnt++;
                else begin
                    bus.mreq_ready = 1'b1;
                    wait_cnt = 0;
                    seq++;
                    if (bus.mreq_write) begin
                        wb_count++;
                        wb_seq       = seq;
                        last_wb_addr = bus.mreq_addr;
                        last_wb_data = bus.mreq_data;
                        mem_store[int'(bus.mreq_addr)] = bus.mreq_data;
                    end else begin
                        fill_count++;
                        fill_seq       = seq;
                        last_fill_addr = bus.mreq_addr;
                        resp_line      = model_line(int'(bus.mreq_addr));
                        resp_pending   = 1;
                        resp_cnt       = fill_latency;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic rd, input logic wr,
                                 input logic [31:0] d, output logic [31:0] dout_o,
                                 output logic hit_o, output int lat);
        int cyc = 0;
        @(negedge clk);
        while (!bus.is_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.is_ready) checkOutput("ready_timeout", 1'b0, 1'b1);
        bus.is_input_valid = 1'b1;
        bus.addr      = a;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.din       = d;
        @(negedge clk);
        bus.is_input_valid = 1'b0;
        lat = 1;
        while (!bus.is_output_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.is_output_valid) checkOutput("done_timeout", 1'b0, 1'b1);
        dout_o = bus.dout;
        hit_o  = bus.is_hit;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        bus.is_input_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] d;
    logic        h;
    int          l, m, f0, w0, cyc;

    initial begin
        reset = 1'b1;
        bus.is_input_valid = 1'b0;
        bus.addr = '0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.din = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready",      bus.is_ready,        1'b1);
        checkOutput("rst_out_valid",  bus.is_output_valid, 1'b0);
        checkOutput("rst_mreq_valid", bus.mreq_valid,      1'b0);
        checkOutput("rst_dout",       bus.dout,            32'd0);
        checkOutput("rst_hit",        bus.is_hit,          1'b0);
        reset = 1'b0;

        // Cold fill, then hits to the same line
        applyStimulus(32'h100, 1, 0, 0, d, h, l);
        checkOutput("cold_fill_count", fill_count, 1);
        checkOutput("cold_fill_addr",  last_fill_addr, 28'h10);
        checkOutput("cold_dout", d, 32'hA000_1000);
        checkOutput("cold_hit",  h, 1'b0);
        m = mreq_cycles;
        applyStimulus(32'h104, 1, 0, 0, d, h, l);
        checkOutput("rep_dout", d, 32'hA000_1001);
        checkOutput("rep_hit",  h, 1'b1);
        checkOutput("rep_lat",  l, 1);
        checkOutput("rep_no_mreq", mreq_cycles, m);
        applyStimulus(32'h108, 0, 1, 32'hDEAD_BEEF, d, h, l);
        checkOutput("st_hit", h, 1'b1);
        checkOutput("st_lat", l, 1);
        checkOutput("st_no_mreq", mreq_cycles, m);
        applyStimulus(32'h108, 1, 0, 0, d, h, l);
        checkOutput("ld_st_dout", d, 32'hDEAD_BEEF);
        checkOutput("ld_st_hit",  h, 1'b1);

        // LRU: third conflicting line evicts the least recent (0x000)
        doReset();
        f0 = fill_count; w0 = wb_count;
        applyStimulus(32'h000, 1, 0, 0, d, h, l);
        applyStimulus(32'h100, 1, 0, 0, d, h, l);
        applyStimulus(32'h200, 1, 0, 0, d, h, l);
        checkOutput("lru_fills", fill_count - f0, 3);
        checkOutput("lru_no_wb", wb_count - w0, 0);
        checkOutput("lru_fill_addr", last_fill_addr, 28'h20);
        checkOutput("lru_dout_200", d, 32'hA000_2000);
        applyStimulus(32'h100, 1, 0, 0, d, h, l);
        checkOutput("lru_100_kept", h, 1'b1);
        applyStimulus(32'h000, 1, 0, 0, d, h, l);
        checkOutput("lru_000_evicted", h, 1'b0);

        // LRU: touching 0x000 first makes 0x100 the victim
        doReset();
        applyStimulus(32'h000, 1, 0, 0, d, h, l);
        applyStimulus(32'h100, 1, 0, 0, d, h, l);
        applyStimulus(32'h000, 1, 0, 0, d, h, l);
        checkOutput("touch_hit", h, 1'b1);
        applyStimulus(32'h200, 1, 0, 0, d, h, l);
        checkOutput("touch_200_miss", h, 1'b0);
        applyStimulus(32'h000, 1, 0, 0, d, h, l);
        checkOutput("touch_000_kept", h, 1'b1);
        applyStimulus(32'h100, 1, 0, 0, d, h, l);
        checkOutput("touch_100_evicted", h, 1'b0);

        // Dirty eviction with a 3-cycle ready stall on every request
        doReset();
        ready_delay = 3;
        w0 = wb_count;
        applyStimulus(32'h000, 0, 1, 32'h11, d, h, l);
        checkOutput("dirty_st_hit", h, 1'b0);
        applyStimulus(32'h100, 1, 0, 0, d, h, l);
        applyStimulus(32'h200, 1, 0, 0, d, h, l);
        checkOutput("wb_count", wb_count - w0, 1);
        checkOutput("wb_addr", last_wb_addr, 28'h00);
        checkOutput("wb_word0", last_wb_data[31:0], 32'h11);
        checkOutput("wb_word1", last_wb_data[63:32], 32'hA000_0001);
        checkOutput("wb_before_fill", wb_seq < fill_seq, 1'b1);
        checkOutput("wb_fill_addr", last_fill_addr, 28'h20);
        checkOutput("wb_dout", d, 32'hA000_2000);
        applyStimulus(32'h200, 1, 0, 0, d, h, l);
        checkOutput("wb_200_hit", h, 1'b1);
`ifdef CACHE_STATS_EN
        checkOutput("stat_access",    stat_access,    32'd4);
        checkOutput("stat_hit",       stat_hit,       32'd1);
        checkOutput("stat_writeback", stat_writeback, 32'd1);
`endif
        applyStimulus(32'h000, 1, 0, 0, d, h, l);
        checkOutput("wb_reload_dout", d, 32'h11);
        checkOutput("wb_reload_hit",  h, 1'b0);
        ready_delay = 0;

        // Reset while waiting for fill data
        doReset();
        fill_latency = 30;
        f0 = fill_count;
        @(negedge clk);
        bus.is_input_valid = 1'b1;
        bus.addr = 32'h300;
        bus.mem_read = 1'b1;
        bus.mem_write = 1'b0;
        @(negedge clk);
        bus.is_input_valid = 1'b0;
        cyc = 0;
        while (fill_count == f0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("midfill_req_seen", fill_count - f0, 1);
        repeat (3) @(negedge clk);
        checkOutput("midfill_busy", bus.is_ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_mreq_valid", bus.mreq_valid, 1'b0);
        checkOutput("midrst_ready",      bus.is_ready,   1'b1);
        @(negedge clk);
        reset = 1'b0;
        fill_latency = 5;
        applyStimulus(32'h300, 1, 0, 0, d, h, l);
        checkOutput("midrst_reload_hit",  h, 1'b0);
        checkOutput("midrst_reload_dout", d, 32'hA000_3000);

        checkOutput("no_overlap", overlap_cycles, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
